// File: rtl/ibex_mem_arbiter_pkg.sv
// Shared types and default widths for the Ibex instruction/data memory arbiter.
package ibex_mem_arb_pkg;

  localparam int unsigned AddrWidthDefault = 15;
  localparam int unsigned DataWidthDefault = 32;
  localparam int unsigned StrbWidthDefault = 32;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } mem_owner_e;

  function automatic mem_owner_e other_owner(input mem_owner_e owner);
    return (owner == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
  endfunction

endpackage

// File: rtl/ibex_mem_arbiter_if.sv
// Request/grant/response memory bus used by both requesters and the shared memory.
interface ibex_mem_arbiter_if
  import ibex_mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth = AddrWidthDefault,
  parameter int unsigned DataWidth = DataWidthDefault,
  parameter int unsigned StrbWidth = StrbWidthDefault
);

  logic                 req;
  logic                 gnt;
  logic [AddrWidth-1:0] addr;
  logic [DataWidth-1:0] wdata;
  logic [StrbWidth-1:0] strb;
  logic                 we;
  logic                 rvalid;
  logic [DataWidth-1:0] rdata;

  // Arbiter side facing a requester.
  modport slave (
    input  req, addr, wdata, strb, we,
    output gnt, rvalid, rdata
  );

  // Arbiter side facing the shared memory; rdata is valid the cycle after gnt.
  modport master (
    output req, addr, wdata, strb, we,
    input  gnt, rdata
  );

endinterface

// File: rtl/ibex_mem_arbiter_rr2.sv
// Two-input round-robin picker; the selection is locked while a request waits for grant.
module ibex_mem_arb_rr2
  import ibex_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_gnt,
  input  logic       i_pend,
  output mem_owner_e o_sel,
  output mem_owner_e o_prio
);

  mem_owner_e prio_q;
  mem_owner_e lock_sel_q;
  logic       lock_q;
  mem_owner_e w_sel;

  // i_req[0] is the instruction port, i_req[1] the data port; idle defaults to DATA.
  always_comb begin
    w_sel = OWN_DATA;
    if (lock_q) begin
      w_sel = lock_sel_q;
    end else begin
      case (i_req)
        2'b01:   w_sel = OWN_INSTR;
        2'b10:   w_sel = OWN_DATA;
        2'b11:   w_sel = prio_q;
        default: w_sel = OWN_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= OWN_DATA;
      lock_q     <= 1'b0;
      lock_sel_q <= OWN_DATA;
    end else begin
      if (i_pend) begin
        lock_q     <= 1'b1;
        lock_sel_q <= w_sel;
      end else if (i_gnt) begin
        lock_q     <= 1'b0;
      end
      if (i_gnt) begin
        prio_q <= other_owner(w_sel);
      end
    end
  end

  assign o_sel  = w_sel;
  assign o_prio = prio_q;

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Shares one single-port memory between the Ibex instruction and data interfaces,
// granting round-robin and routing the one-cycle read response back to its owner.
module ibex_mem_arbiter
  import ibex_mem_arb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  ibex_mem_arbiter_if.slave   instr_if,
  ibex_mem_arbiter_if.slave   data_if,
  ibex_mem_arbiter_if.master  mem_if
);

  logic       w_memReq;
  logic       w_gnt;
  logic       w_pend;
  mem_owner_e w_sel;
  mem_owner_e w_prio;
  mem_owner_e rsp_own_q;
  logic       rsp_vld_q;

  assign w_memReq = instr_if.req | data_if.req;
  // Grants are forced low while reset is held so nothing is accepted during reset.
  assign w_gnt    = mem_if.gnt & w_memReq & ~rst_i;
  assign w_pend   = w_memReq & ~mem_if.gnt;

  ibex_mem_arb_rr2 u_rr2 (
    .clk    (clk_i),
    .rst    (rst_i),
    .i_req  ({data_if.req, instr_if.req}),
    .i_gnt  (w_gnt),
    .i_pend (w_pend),
    .o_sel  (w_sel),
    .o_prio (w_prio)
  );

  assign mem_if.req   = w_memReq;
  assign mem_if.addr  = (w_sel == OWN_INSTR) ? instr_if.addr  : data_if.addr;
  assign mem_if.wdata = (w_sel == OWN_INSTR) ? instr_if.wdata : data_if.wdata;
  assign mem_if.strb  = (w_sel == OWN_INSTR) ? instr_if.strb  : data_if.strb;
  assign mem_if.we    = (w_sel == OWN_INSTR) ? instr_if.we    : data_if.we;

  assign instr_if.gnt = w_gnt & (w_sel == OWN_INSTR);
  assign data_if.gnt  = w_gnt & (w_sel == OWN_DATA);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_vld_q <= 1'b0;
      rsp_own_q <= OWN_DATA;
    end else begin
      rsp_vld_q <= w_gnt;
      if (w_gnt) begin
        rsp_own_q <= w_sel;
      end
    end
  end

  assign instr_if.rvalid = rsp_vld_q & (rsp_own_q == OWN_INSTR);
  assign data_if.rvalid  = rsp_vld_q & (rsp_own_q == OWN_DATA);
  // Read data fans out unqualified; consumers look at rvalid.
  assign instr_if.rdata  = mem_if.rdata;
  assign data_if.rdata   = mem_if.rdata;

  logic w_unusedPrio;
  assign w_unusedPrio = (w_prio == OWN_DATA);

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed testbench for ibex_mem_arbiter with hand-computed expectations.
module tb_ibex_mem_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ibex_mem_arbiter_if instrIf ();
  ibex_mem_arbiter_if dataIf ();
  ibex_mem_arbiter_if memIf ();

  assign memIf.rvalid = 1'b0;

  ibex_mem_arbiter dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .instr_if (instrIf),
    .data_if  (dataIf),
    .mem_if   (memIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    instrIf.req = 1'b0; instrIf.addr = 15'h0100; instrIf.wdata = 32'h0; instrIf.strb = 32'h0; instrIf.we = 1'b0;
    dataIf.req  = 1'b0; dataIf.addr  = 15'h0200; dataIf.wdata  = 32'h0; dataIf.strb  = 32'h0; dataIf.we  = 1'b0;
    memIf.gnt   = 1'b0; memIf.rdata  = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setIdle();
    instrIf.req = 1'b1;
    dataIf.req  = 1'b1;
    memIf.gnt   = 1'b1;
    nextCycle();
    nextCycle();
    @(negedge clk);
    vectors++; if (instrIf.gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_instr_gnt: got %b expected 0", instrIf.gnt); end
    vectors++; if (dataIf.gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_data_gnt: got %b expected 0", dataIf.gnt); end
    vectors++; if (instrIf.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_instr_rvalid: got %b expected 0", instrIf.rvalid); end
    vectors++; if (dataIf.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_data_rvalid: got %b expected 0", dataIf.rvalid); end
    vectors++; if (memIf.addr !== 15'h0200) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h expected 0200", memIf.addr); end
    vectors++; if (memIf.req !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_mem_req: got %b expected 1", memIf.req); end
    setIdle();
    rst = 1'b0;
    nextCycle();
  endtask

  task automatic test_data_read();
    dataIf.req  = 1'b1;
    dataIf.addr = 15'h0010;
    memIf.gnt   = 1'b1;
    @(negedge clk);
    vectors++; if (dataIf.gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL read_data_gnt: got %b expected 1", dataIf.gnt); end
    vectors++; if (instrIf.gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL read_instr_gnt: got %b expected 0", instrIf.gnt); end
    vectors++; if (memIf.addr !== 15'h0010) begin miscompares++; $display("[TB] FAIL read_mem_addr: got %h expected 0010", memIf.addr); end
    vectors++; if (memIf.we !== 1'b0) begin miscompares++; $display("[TB] FAIL read_mem_we: got %b expected 0", memIf.we); end
    nextCycle();
    setIdle();
    memIf.rdata = 32'h1234_5678;
    @(negedge clk);
    vectors++; if (dataIf.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL read_data_rvalid: got %b expected 1", dataIf.rvalid); end
    vectors++; if (dataIf.rdata !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL read_data_rdata: got %h expected 12345678", dataIf.rdata); end
    vectors++; if (instrIf.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL read_instr_rvalid: got %b expected 0", instrIf.rvalid); end
    nextCycle();
    @(negedge clk);
    vectors++; if (dataIf.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL read_rvalid_drop: got %b expected 0", dataIf.rvalid); end
    nextCycle();
  endtask

  task automatic test_round_robin();
    logic expData;
    logic prevData;
    rst = 1'b1;
    setIdle();
    nextCycle();
    rst = 1'b0;
    nextCycle();
    instrIf.req = 1'b1;
    dataIf.req  = 1'b1;
    memIf.gnt   = 1'b1;
    prevData    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expData = (i % 2 == 0);
      @(negedge clk);
      vectors++; if (dataIf.gnt !== expData) begin miscompares++; $display("[TB] FAIL rr_data_gnt[%0d]: got %b expected %b", i, dataIf.gnt, expData); end
      vectors++; if (instrIf.gnt !== !expData) begin miscompares++; $display("[TB] FAIL rr_instr_gnt[%0d]: got %b expected %b", i, instrIf.gnt, !expData); end
      vectors++; if (memIf.addr !== (expData ? 15'h0200 : 15'h0100)) begin miscompares++; $display("[TB] FAIL rr_mem_addr[%0d]: got %h expected %h", i, memIf.addr, expData ? 15'h0200 : 15'h0100); end
      if (i > 0) begin
        vectors++; if (dataIf.rvalid !== prevData) begin miscompares++; $display("[TB] FAIL rr_data_rvalid[%0d]: got %b expected %b", i, dataIf.rvalid, prevData); end
        vectors++; if (instrIf.rvalid !== !prevData) begin miscompares++; $display("[TB] FAIL rr_instr_rvalid[%0d]: got %b expected %b", i, instrIf.rvalid, !prevData); end
      end else begin
        vectors++; if ((dataIf.rvalid | instrIf.rvalid) !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_rvalid_first: got %b/%b expected 0/0", instrIf.rvalid, dataIf.rvalid); end
      end
      prevData = expData;
      nextCycle();
    end
    instrIf.req = 1'b0;
    dataIf.req  = 1'b0;
    @(negedge clk);
    vectors++; if (instrIf.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL rr_last_instr_rvalid: got %b expected 1", instrIf.rvalid); end
    vectors++; if (dataIf.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_last_data_rvalid: got %b expected 0", dataIf.rvalid); end
    nextCycle();
    setIdle();
  endtask

  task automatic test_lock();
    instrIf.req = 1'b1;
    dataIf.req  = 1'b1;
    memIf.gnt   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) memIf.gnt = 1'b1;
      @(negedge clk);
      vectors++; if (memIf.addr !== 15'h0200) begin miscompares++; $display("[TB] FAIL stall_mem_addr[%0d]: got %h expected 0200", i, memIf.addr); end
      vectors++; if (dataIf.gnt !== (i == 3)) begin miscompares++; $display("[TB] FAIL stall_data_gnt[%0d]: got %b expected %b", i, dataIf.gnt, (i == 3)); end
      vectors++; if (instrIf.gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_instr_gnt[%0d]: got %b expected 0", i, instrIf.gnt); end
      nextCycle();
    end
    @(negedge clk);
    vectors++; if (memIf.addr !== 15'h0100) begin miscompares++; $display("[TB] FAIL stall_after_addr: got %h expected 0100", memIf.addr); end
    vectors++; if (instrIf.gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_after_instr_gnt: got %b expected 1", instrIf.gnt); end
    vectors++; if (dataIf.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_data_rvalid: got %b expected 1", dataIf.rvalid); end
    nextCycle();
    setIdle();
    nextCycle();
    // INSTR stalls alone; DATA joining while prio favours DATA must not steal the slot.
    instrIf.req = 1'b1;
    @(negedge clk);
    vectors++; if (memIf.addr !== 15'h0100) begin miscompares++; $display("[TB] FAIL lock_first_addr: got %h expected 0100", memIf.addr); end
    nextCycle();
    dataIf.req = 1'b1;
    @(negedge clk);
    vectors++; if (memIf.addr !== 15'h0100) begin miscompares++; $display("[TB] FAIL lock_held_addr: got %h expected 0100", memIf.addr); end
    nextCycle();
    memIf.gnt = 1'b1;
    @(negedge clk);
    vectors++; if (instrIf.gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_instr_gnt: got %b expected 1", instrIf.gnt); end
    vectors++; if (dataIf.gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL lock_data_gnt: got %b expected 0", dataIf.gnt); end
    nextCycle();
    instrIf.req = 1'b0;
    @(negedge clk);
    vectors++; if (dataIf.gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_next_data_gnt: got %b expected 1", dataIf.gnt); end
    vectors++; if (instrIf.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_instr_rvalid: got %b expected 1", instrIf.rvalid); end
    nextCycle();
    setIdle();
    nextCycle();
  endtask

  task automatic test_write();
    dataIf.req   = 1'b1;
    dataIf.we    = 1'b1;
    dataIf.addr  = 15'h0040;
    dataIf.wdata = 32'hDEAD_BEEF;
    dataIf.strb  = 32'h0000_FFFF;
    memIf.gnt    = 1'b1;
    @(negedge clk);
    vectors++; if (memIf.we !== 1'b1) begin miscompares++; $display("[TB] FAIL write_mem_we: got %b expected 1", memIf.we); end
    vectors++; if (memIf.wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL write_mem_wdata: got %h expected deadbeef", memIf.wdata); end
    vectors++; if (memIf.strb !== 32'h0000_FFFF) begin miscompares++; $display("[TB] FAIL write_mem_strb: got %h expected 0000ffff", memIf.strb); end
    vectors++; if (dataIf.gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL write_data_gnt: got %b expected 1", dataIf.gnt); end
    nextCycle();
    setIdle();
    @(negedge clk);
    vectors++; if (dataIf.rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL write_data_rvalid: got %b expected 1", dataIf.rvalid); end
    nextCycle();
    @(negedge clk);
    vectors++; if (dataIf.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL write_rvalid_once: got %b expected 0", dataIf.rvalid); end
    nextCycle();
  endtask

  task automatic test_reset_mid();
    dataIf.req = 1'b1;
    memIf.gnt  = 1'b1;
    @(negedge clk);
    vectors++; if (dataIf.gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_data_gnt: got %b expected 1", dataIf.gnt); end
    @(posedge clk);
    rst = 1'b1;
    setIdle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++; if ((dataIf.rvalid | instrIf.rvalid) !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_rvalid[%0d]: got %b/%b expected 0/0", i, instrIf.rvalid, dataIf.rvalid); end
    end
    nextCycle();
    rst = 1'b0;
    instrIf.req = 1'b1;
    dataIf.req  = 1'b1;
    memIf.gnt   = 1'b1;
    @(negedge clk);
    vectors++; if (dataIf.rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_after_rvalid: got %b expected 0", dataIf.rvalid); end
    vectors++; if (dataIf.gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_first_data_gnt: got %b expected 1", dataIf.gnt); end
    vectors++; if (instrIf.gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_first_instr_gnt: got %b expected 0", instrIf.gnt); end
    nextCycle();
    setIdle();
    nextCycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    setIdle();
    test_reset();
    test_data_read();
    test_round_robin();
    test_lock();
    test_write();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
